// File: rtl/snake_step_timer.sv
// ---------------------------------------------------------------------------
// snake_step_timer
//
// Turns the slow divider level clk_1s into one-cycle tick pulses and paces
// snake moves from those ticks. Every clk_1s transition (rise or fall) is one
// tick. A 2-bit divider groups ticks into moves according to speed. Each move
// is held as a request until the game logic acknowledges it. A move that falls
// due while the previous one is still unacknowledged is counted as a miss.
//
// Parameters
//   SYNC_STAGES  number of synchronizer flops on clk_1s (2..4)
//
// Ports
//   clk         system clock; every flop updates on its rising edge
//   rst         asynchronous, active-high reset
//   clk_1s      slow toggling level; each edge of it is one tick
//   speed[1:0]  move rate: 0 = one move per 4 ticks, 1 = per 3, 2 = per 2,
//               3 = one move per tick
//   pause       while high, ticks do not advance the move divider
//   move_ack    game logic accepts the pending move
//   tick_pulse  one-cycle pulse for each clk_1s transition
//   move_req    a move is pending
//   miss_cnt    count of moves that fell due while one was pending; stops at 15
// ---------------------------------------------------------------------------
module snake_step_timer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_1s,
   input  logic [1:0] speed,
   input  logic       pause,
   input  logic       move_ack,
   output logic       tick_pulse,
   output logic       move_req,
   output logic [3:0] miss_cnt
);

   localparam int PRIME_CYCLES = SYNC_STAGES + 1;
   localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } move_state_t;

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   prev_p1;
   logic [PRIME_W-1:0]     prime_cnt;
   logic                   primed;
   logic                   tick;
   logic [1:0]             div_cnt;
   logic [2:0]             thresh;
   logic [2:0]             div_next;
   logic                   due;
   move_state_t            state;

   // Increment that holds at the top value instead of wrapping.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // ---- stage p0/p1: synchronizer chain and history flop ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0   <= '0;
         prev_p1   <= 1'b0;
         prime_cnt <= '0;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], clk_1s};
         prev_p1 <= sync_p0[SYNC_STAGES-1];
         if (!primed) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
         end
      end
   end

   // Until the chain has refilled after reset, the difference between the
   // last sync stage and prev reflects the reset value, not a real edge, so
   // it must not count as a tick (e.g. clk_1s held high through reset).
   assign primed = (prime_cnt == PRIME_W'(PRIME_CYCLES));
   assign tick   = primed & (sync_p0[SYNC_STAGES-1] ^ prev_p1);

   // Threshold 4 - speed uses 3 bits, because speed 0 needs the value 4.
   // The >= comparison (rather than ==) means that lowering the threshold
   // mid-count makes the next tick due instead of wrapping past it.
   assign thresh   = 3'd4 - {1'b0, speed};
   assign div_next = {1'b0, div_cnt} + 3'd1;
   assign due      = tick & ~pause & (div_next >= thresh);

   // ---- stage p2: tick pulse, move divider and move request FSM ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_pulse <= 1'b0;
         div_cnt    <= 2'd0;
         miss_cnt   <= 4'd0;
         state      <= IDLE;
      end else begin
         tick_pulse <= tick;
         if (tick && !pause) begin
            div_cnt <= due ? 2'd0 : div_next[1:0];
         end
         case (state)
            IDLE: begin
               if (due) begin
                  state <= PEND;
               end
            end
            PEND: begin
               // A new move arriving with an ack replaces the old one; only
               // an unacknowledged overlap counts as a miss.
               if (due) begin
                  if (!move_ack) begin
                     miss_cnt <= sat_inc4(miss_cnt);
                  end
               end else if (move_ack) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign move_req = (state == PEND);

endmodule

// File: tb/tb_snake_step_timer.sv
module tb_snake_step_timer;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1s;
  logic [1:0] speed;
  logic       pause;
  logic       move_ack;
  logic       tick_pulse;
  logic       move_req;
  logic [3:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  int dut_ticks = 0;
  int dut_rises = 0;
  bit prev_req = 1'b0;

  // ack policy: 0 = never, 1 = pulse ack_dly+1 cycles after request, 2 = random
  int ack_mode = 0;
  int ack_dly = 1;
  int ack_wait = 0;

  // reference model state
  int   m_edge;
  logic hist[$];
  int   m_phase;
  bit   m_pend;
  int   m_miss;

  snake_step_timer #(.SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_1s     (clk_1s),
    .speed      (speed),
    .pause      (pause),
    .move_ack   (move_ack),
    .tick_pulse (tick_pulse),
    .move_req   (move_req),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edge = 0;
    hist = {};
    repeat (SS + 2) hist.push_back(1'b0);
    m_phase = 0;
    m_pend = 1'b0;
    m_miss = 0;
    ack_wait = 0;
    prev_req = 1'b0;
  endtask

  // One clock cycle: capture inputs seen at the edge, advance the model from
  // the behavioural rules, compare, then choose the next move_ack.
  task automatic step();
    logic       s_lvl, s_pause, s_ack;
    logic [1:0] s_spd;
    bit         exp_tick, due;
    s_lvl = clk_1s; s_pause = pause; s_ack = move_ack; s_spd = speed;
    @(posedge clk);
    #1;
    m_edge++;
    hist.push_front(s_lvl);
    void'(hist.pop_back());
    // A transition is reported once the new level has been sampled SS edges
    // earlier; nothing is reported during the first SS+1 edges after reset.
    exp_tick = (m_edge >= SS + 2) && (hist[SS] !== hist[SS+1]);
    due = 1'b0;
    if (exp_tick && !s_pause) begin
      if (m_phase + 1 >= 4 - int'(s_spd)) begin
        due = 1'b1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    if (m_pend) begin
      if (due) begin
        if (!s_ack && m_miss < 15) m_miss++;
      end else if (s_ack) begin
        m_pend = 1'b0;
      end
    end else if (due) begin
      m_pend = 1'b1;
    end
    chk("tick_pulse", tick_pulse, exp_tick);
    chk("move_req", move_req, m_pend);
    chk("miss_cnt", miss_cnt, m_miss);
    if (tick_pulse) dut_ticks++;
    if (move_req && !prev_req) dut_rises++;
    prev_req = move_req;
    move_ack = 1'b0;
    case (ack_mode)
      1: begin
        if (m_pend) begin
          if (ack_wait >= ack_dly) begin
            move_ack = 1'b1;
            ack_wait = 0;
          end else begin
            ack_wait++;
          end
        end else begin
          ack_wait = 0;
        end
      end
      2: move_ack = ($urandom_range(3, 0) == 0);
      default: ;
    endcase
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic toggles(input int n, input int lo, input int hi);
    repeat (n) begin
      clk_1s = ~clk_1s;
      steps($urandom_range(hi, lo));
    end
  endtask

  // Reset pulse entirely between two rising edges; outputs must clear at once.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_move_req", move_req, 0);
    chk("async_rst_miss_cnt", miss_cnt, 0);
    chk("async_rst_div_cnt", dut.div_cnt, 0);
    chk("async_rst_tick", tick_pulse, 0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int base_r, base_t;
    rst = 1'b1; clk_1s = 1'b1; speed = 2'd3; pause = 1'b0; move_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tick", tick_pulse, 0);
    chk("reset_move_req", move_req, 0);
    chk("reset_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    model_reset();

    // clk_1s high through reset: no tick while priming, then one per toggle
    ack_mode = 1; ack_dly = 1;
    steps(10);
    chk("prime_no_tick", dut_ticks, 0);
    toggles(1, 10, 10);
    chk("first_toggle_one_tick", dut_ticks, 1);

    // speed 3: one move per tick, each acknowledged two cycles later
    base_r = dut_rises; base_t = dut_ticks;
    toggles(6, 20, 20);
    chk("spd3_ticks", dut_ticks - base_t, 6);
    chk("spd3_moves", dut_rises - base_r, 6);
    chk("spd3_miss", miss_cnt, 0);

    // speed 0: moves on the 4th and 8th tick only
    speed = 2'd0;
    base_r = dut_rises;
    toggles(3, 20, 20);
    chk("spd0_none_before_4th", dut_rises - base_r, 0);
    toggles(1, 20, 20);
    chk("spd0_move_on_4th", dut_rises - base_r, 1);
    toggles(4, 20, 20);
    chk("spd0_move_on_8th", dut_rises - base_r, 2);

    // speed 2, never acknowledged: one long request, misses saturate
    speed = 2'd2; ack_mode = 0;
    base_r = dut_rises;
    toggles(40, 3, 10);
    chk("spd2_single_request", dut_rises - base_r, 1);
    chk("spd2_miss_sat", miss_cnt, 15);
    chk("spd2_still_pending", move_req, 1);

    // asynchronous reset drops the request; a later ack does nothing
    pulse_reset();
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    step();
    chk("ack_after_rst_ignored", move_req, 0);
    steps(6);

    // speed 1 with a pause window after two ticks
    speed = 2'd1; ack_mode = 1; ack_dly = 1;
    base_r = dut_rises;
    toggles(2, 8, 8);
    pause = 1'b1;
    base_t = dut_ticks;
    toggles(5, 8, 8);
    chk("pause_ticks_continue", dut_ticks - base_t, 5);
    chk("pause_no_move", dut_rises - base_r, 0);
    pause = 1'b0;
    toggles(1, 8, 8);
    chk("move_after_unpause", dut_rises - base_r, 1);

    // randomized mix: speed changes mid-count, pauses, random acks
    ack_mode = 2;
    repeat (80) begin
      speed = 2'($urandom_range(3, 0));
      pause = ($urandom_range(4, 0) == 0);
      clk_1s = ~clk_1s;
      repeat ($urandom_range(12, 3)) begin
        if ($urandom_range(7, 0) == 0) speed = 2'($urandom_range(3, 0));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
